// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - format helpers for the fp_add IEEE-754 adder
package fp_pkg;

    // Fields sized for the widest format; narrower formats use the low bits.
    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [51:0] frac;
    } fp_fields_t;

    function automatic int exp_w_of(input int width);
        case (width)
            32:      return 8;
            64:      return 11;
            default: return 5;
        endcase
    endfunction

    function automatic int frac_w_of(input int width);
        case (width)
            32:      return 23;
            64:      return 52;
            default: return 10;
        endcase
    endfunction

    function automatic int bias_of(input int width);
        return (1 << (exp_w_of(width) - 1)) - 1;
    endfunction

    function automatic logic [63:0] inf_bits(input int width);
        return ((64'd1 << exp_w_of(width)) - 64'd1) << frac_w_of(width);
    endfunction

    function automatic logic [63:0] qnan_bits(input int width);
        return inf_bits(width) | (64'd1 << (frac_w_of(width) - 1));
    endfunction

    function automatic fp_fields_t fp_unpack(input int width, input logic [63:0] bits);
        fp_fields_t f;
        f.sign = |((bits >> (width - 1)) & 64'd1);
        f.exp  = 11'((bits >> frac_w_of(width)) & ((64'd1 << exp_w_of(width)) - 64'd1));
        f.frac = 52'(bits & ((64'd1 << frac_w_of(width)) - 64'd1));
        return f;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter
module fp_lzc #(
    parameter int W = 14
) (
    input  logic [W-1:0]         data,
    output logic [$clog2(W):0]   count
);
    logic found;

    always_comb begin
        count = ($clog2(W)+1)'(W);
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && data[i]) begin
                count = ($clog2(W)+1)'(W - 1 - i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp_add.sv
// rtl/fp_add.sv - 2-stage pipelined IEEE-754 adder; FP_ADD_FTZ_EN enables flush-to-zero
module fp_add
    import fp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);
    localparam int EXP_W  = exp_w_of(WIDTH);
    localparam int FRAC_W = frac_w_of(WIDTH);
    localparam int SIG_W  = FRAC_W + 1;
    localparam int EXT_W  = SIG_W + 3;
    localparam int SUM_W  = EXT_W + 1;
    localparam int LZ_W   = $clog2(EXT_W) + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W:0]   EXP1    = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] QNAN    = WIDTH'(qnan_bits(WIDTH));

    if (!(WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
        $error("fp_add: unsupported WIDTH %0d", WIDTH);
    end

    fp_fields_t ua, ub;
    logic [EXP_W-1:0]  ea, eb, xa, xb, x_big, x_small, d;
    logic [FRAC_W-1:0] fa, fb;
    logic [SIG_W-1:0]  ma, mb, m_big, m_small;
    logic [EXT_W-1:0]  ext_s, shifted, aligned;
    logic [SUM_W-1:0]  sum;
    logic              s_big, swap, sticky, a_nan, b_nan, a_inf, b_inf;
    logic              special;
    logic [WIDTH-1:0]  special_val;

    assign ua = fp_unpack(WIDTH, 64'(a));
    assign ub = fp_unpack(WIDTH, 64'(b));
    assign ea = EXP_W'(ua.exp);
    assign eb = EXP_W'(ub.exp);
    assign fa = FRAC_W'(ua.frac);
    assign fb = FRAC_W'(ub.frac);

`ifdef FP_ADD_FTZ_EN
    assign ma = (ea == '0) ? '0 : {1'b1, fa};
    assign mb = (eb == '0) ? '0 : {1'b1, fb};
`else
    assign ma = {ea != '0, fa};
    assign mb = {eb != '0, fb};
`endif
    // Subnormals share the exponent of the smallest normal.
    assign xa = (ea == '0) ? EXP_W'(1) : ea;
    assign xb = (eb == '0) ? EXP_W'(1) : eb;

    assign a_nan = (ea == EXP_MAX) && (fa != '0);
    assign b_nan = (eb == EXP_MAX) && (fb != '0);
    assign a_inf = (ea == EXP_MAX) && (fa == '0);
    assign b_inf = (eb == EXP_MAX) && (fb == '0);

    assign swap    = {eb, fb} > {ea, fa};
    assign x_big   = swap ? xb : xa;
    assign x_small = swap ? xa : xb;
    assign m_big   = swap ? mb : ma;
    assign m_small = swap ? ma : mb;
    assign s_big   = swap ? ub.sign : ua.sign;
    assign d       = x_big - x_small;

    // Shifts past the field leave zero data and fold everything into sticky.
    assign ext_s   = {m_small, 3'b000};
    assign shifted = ext_s >> d;
    assign sticky  = |(ext_s & ~({EXT_W{1'b1}} << d));
    assign aligned = {shifted[EXT_W-1:1], shifted[0] | sticky};
    assign sum     = (ua.sign ^ ub.sign) ? {1'b0, m_big, 3'b000} - {1'b0, aligned}
                                         : {1'b0, m_big, 3'b000} + {1'b0, aligned};

    always_comb begin
        special     = 1'b1;
        special_val = QNAN;
        if (a_nan || b_nan || (a_inf && b_inf && (ua.sign != ub.sign)))
            special_val = QNAN;
        else if (a_inf)
            special_val = a;
        else if (b_inf)
            special_val = b;
        else
            special = 1'b0;
    end

    logic             s1_special, s1_sign;
    logic [WIDTH-1:0] s1_special_val;
    logic [EXP_W:0]   s1_exp;
    logic [SUM_W-1:0] s1_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_special     <= 1'b0;
            s1_special_val <= '0;
            s1_sign        <= 1'b0;
            s1_exp         <= '0;
            s1_sum         <= '0;
        end else begin
            s1_special     <= special;
            s1_special_val <= special_val;
            s1_sign        <= (sum == '0) ? (ua.sign & ub.sign) : s_big;
            s1_exp         <= {1'b0, x_big};
            s1_sum         <= sum;
        end
    end

    logic [LZ_W-1:0]   lz;
    logic [EXP_W:0]    lz_e, shamt, exp_n, exp_r;
    logic [EXT_W-1:0]  norm;
    logic [SIG_W:0]    mant;
    logic [FRAC_W-1:0] frac_r;
    logic              round_up;
    logic [WIDTH-1:0]  res_n;

    fp_lzc #(.W(EXT_W)) u_lzc (
        .data  (s1_sum[EXT_W-1:0]),
        .count (lz)
    );

    always_comb begin
        lz_e  = (EXP_W+1)'(lz);
        shamt = '0;
        if (s1_sum[SUM_W-1]) begin
            norm  = {s1_sum[SUM_W-1:2], |s1_sum[1:0]};
            exp_n = s1_exp + EXP1;
        end else begin
            // Stop normalizing at the minimum exponent; the rest stays subnormal.
            shamt = (lz_e < s1_exp - EXP1) ? lz_e : s1_exp - EXP1;
            norm  = s1_sum[EXT_W-1:0] << shamt;
            exp_n = s1_exp - shamt;
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant     = {1'b0, norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, round_up};
        if (mant[SIG_W]) begin
            exp_r  = exp_n + EXP1;
            frac_r = '0;
        end else begin
            exp_r  = mant[SIG_W-1] ? exp_n : '0;
            frac_r = mant[FRAC_W-1:0];
        end
        if (s1_special)
            res_n = s1_special_val;
        else if (s1_sum == '0)
            res_n = {s1_sign, {(WIDTH-1){1'b0}}};
        else if (exp_r >= {1'b0, EXP_MAX})
            res_n = {s1_sign, EXP_MAX, {FRAC_W{1'b0}}};
`ifdef FP_ADD_FTZ_EN
        else if (exp_r == '0)
            res_n = {s1_sign, {(WIDTH-1){1'b0}}};
`endif
        else
            res_n = {s1_sign, exp_r[EXP_W-1:0], frac_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            result <= '0;
        else
            result <= res_n;
    end
endmodule

// File: tb/tb_fp_add.sv
// tb/tb_fp_add.sv - directed and random checks of fp_add (WIDTH=16), honours FP_ADD_FTZ_EN
module tb_fp_add;
    logic        clk;
    logic        rst_n;
    logic [15:0] a, b;
    logic [15:0] result;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] pipe1, exp_res;

    fp_add #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Value in units of 2^-24, which is exact for every half-precision number.
    function automatic longint units(input logic [15:0] x);
        longint m;
        if (x[14:10] == 5'd0) begin
`ifdef FP_ADD_FTZ_EN
            m = 0;
`else
            m = longint'(x[9:0]);
`endif
        end else begin
            m = longint'({1'b1, x[9:0]}) << (x[14:10] - 1);
        end
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
        logic   xn, yn, xi, yi, sg;
        longint s, m, q, rem, halfv;
        int     p, sh;
        logic [4:0] e5;
        xn = (&x[14:10]) && (|x[9:0]);
        yn = (&y[14:10]) && (|y[9:0]);
        xi = (&x[14:10]) && !(|x[9:0]);
        yi = (&y[14:10]) && !(|y[9:0]);
        if (xn || yn || (xi && yi && (x[15] != y[15]))) return 16'h7E00;
        if (xi) return x;
        if (yi) return y;
        s = units(x) + units(y);
        if (s == 0) return (x[15] & y[15]) ? 16'h8000 : 16'h0000;
        sg = (s < 0);
        m  = sg ? -s : s;
        p  = 0;
        for (int i = 0; i < 48; i++)
            if ((m >> i) != 0) p = i;
        sh  = (p > 10) ? p - 10 : 0;
        q   = m >> sh;
        rem = m - (q << sh);
        if (sh > 0) begin
            halfv = longint'(1) << (sh - 1);
            if (rem > halfv || (rem == halfv && q[0])) q++;
        end
        if (q == 2048) begin
            q = 1024;
            sh++;
        end
        if (q < 1024) begin
`ifdef FP_ADD_FTZ_EN
            return {sg, 15'd0};
`else
            return {sg, 5'd0, q[9:0]};
`endif
        end
        if (sh + 1 >= 31) return {sg, 15'h7C00};
        e5 = 5'(sh + 1);
        return {sg, e5, q[9:0]};
    endfunction

    task automatic apply(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] expv);
        a = va;
        b = vb;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq(tag, result, expv);
    endtask

    task automatic stream_cycle(input logic [15:0] na, input logic [15:0] nb);
        @(posedge clk);
        if (!rst_n) begin
            exp_res = 16'h0000;
            pipe1   = 16'h0000;
        end else begin
            exp_res = pipe1;
            pipe1   = ref_add(a, b);
        end
        @(negedge clk);
        check_eq("stream", result, exp_res);
        a = na;
        b = nb;
    endtask

    function automatic logic [15:0] pick_b(input logic [15:0] x);
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 3))
            0: return r;
            1: return x ^ 16'h8000 ^ {12'd0, r[3:0]};
            2: return {r[15], x[14:10] ^ {3'd0, r[1:0]}, r[9:0]};
            default: return {r[15], 5'd0, r[9:0]};
        endcase
    endfunction

    initial begin
        logic [15:0] ra;
        rst_n = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_zero", result, 16'h0000);

        rst_n = 1'b1;
        a = 16'h3C00; b = 16'h3C00;
        @(posedge clk);
        @(negedge clk);
        a = 16'h3C00; b = 16'hBC00;
        @(posedge clk);
        @(negedge clk);
        check_eq("one_plus_one", result, 16'h4000);
        @(posedge clk);
        @(negedge clk);
        check_eq("cancel_pos_zero", result, 16'h0000);

        apply("tie_even_down", 16'h3C00, 16'h1000, 16'h3C00);
        apply("tie_even_up",   16'h3C01, 16'h1000, 16'h3C02);
        apply("overflow_inf",  16'h7BFF, 16'h7BFF, 16'h7C00);
        apply("inf_minus_inf", 16'h7C00, 16'hFC00, 16'h7E00);
        apply("nan_in",        16'h7C01, 16'h3C00, 16'h7E00);
        apply("neg_inf_fin",   16'hFC00, 16'h3C00, 16'hFC00);
`ifdef FP_ADD_FTZ_EN
        apply("sub_plus_sub",  16'h0001, 16'h0001, 16'h0000);
        apply("sub_to_normal", 16'h03FF, 16'h0001, 16'h0000);
`else
        apply("sub_plus_sub",  16'h0001, 16'h0001, 16'h0002);
        apply("sub_to_normal", 16'h03FF, 16'h0001, 16'h0400);
`endif
        apply("neg_zeros",     16'h8000, 16'h8000, 16'h8000);
        apply("pos_neg_zero",  16'h0000, 16'h8000, 16'h0000);

        pipe1 = ref_add(a, b);
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_async", result, 16'h0000);
            end
            if (i == 503) rst_n = 1'b1;
            ra = 16'($urandom);
            stream_cycle(ra, pick_b(ra));
        end
        stream_cycle(16'h0000, 16'h0000);
        stream_cycle(16'h0000, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_add.md
Name: fp_add

Overview:
- Pipelined IEEE-754 binary floating-point adder, parameterized by total format width (half/single/double).
- Free-running datapath: a new operand pair is accepted every clock, with no handshake.
- Leaf arithmetic block used by the FP datapath; the bench drives `a`/`b` and samples `result` through a parameterized interface of the same WIDTH.

Parameters:
- WIDTH, 16, total format width. Legal values:
  - 16: 5-bit exponent, 10-bit fraction.
  - 32: 8-bit exponent, 23-bit fraction.
  - 64: 11-bit exponent, 52-bit fraction.
  - Any other value is an elaboration-time error.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- a  input  WIDTH  operand A (IEEE-754 encoding).
- b  input  WIDTH  operand B (IEEE-754 encoding).
- result  output  WIDTH  rounded sum a+b.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- Reset values: all pipeline registers clear to 0 immediately on rst_n low; `result` = 0 (+0.0) during reset.
- Latency is fixed at 2 cycles. Operands sampled at rising edge N appear on `result` after rising edge N+2.
- Throughput is one operation per cycle.
- Reset mid-operation: all in-flight operations are discarded. After rst_n deasserts, `result` stays 0 until the first post-reset operands have traversed 2 edges.
- Stage 1 (unpack/align/add):
  - Unpack sign, exponent and significand; hidden bit = 1 for normals, 0 for subnormals (subnormal effective exponent = 1).
  - Swap so the larger magnitude is first.
  - Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits. Shifts beyond the significand width collapse to sticky only.
  - Add or subtract the significands according to the effective operation (sign xor).
- Stage 2 (normalize/round/pack):
  - Normalize using a leading-zero count; carry-out shifts right by 1.
  - Round to nearest, ties to even.
  - Rounding carry that overflows the significand increments the exponent.
- Special cases, evaluated in stage 1 and carried alongside the data:
  - Any NaN input -> canonical quiet NaN: sign 0, exponent all ones, fraction MSB 1, rest 0 (0x7E00 for half).
  - +inf + -inf -> canonical quiet NaN.
  - inf + finite -> that inf.
  - Overflow after rounding -> inf with the result sign.
- Zero sign rules:
  - An exact-zero result from the sum of opposite-signed nonzero operands is +0.
  - (+0)+(-0) = +0.
  - (-0)+(-0) = -0.
- Subnormal inputs and outputs are fully supported (gradual underflow).
- Exception flags are not generated.

Optional Feature:
- Macro: FP_ADD_FTZ_EN.
- Defined:
  - Subnormal inputs are treated as signed zero.
  - Any result whose rounded magnitude is below the minimum normal is replaced by zero with the result sign.
- Undefined: full subnormal handling as described in Behaviour.

Decomposition:
- Package fp_pkg holds:
  - Functions/constants deriving EXP_W, FRAC_W and BIAS from WIDTH.
  - Canonical qNaN and inf bit patterns per width.
  - A packed struct typedef {sign, exp, frac}.
- One sub-module: fp_lzc.
  - Parameterized leading-zero counter used by stage-2 normalization.
  - Purely combinational.
  - Output width $clog2(input width)+1.

Test Plan (WIDTH=16, result checked 2 cycles after drive):
- Reset and simple sums:
  - Hold rst_n low -> result 0x0000.
  - Release, drive 0x3C00+0x3C00 -> 0x4000.
  - Next cycle drive 0x3C00+0xBC00 -> 0x0000 (+0).
- Rounding, ties to even:
  - 0x3C00+0x1000 (1+2^-11, tie) -> 0x3C00.
  - 0x3C01+0x1000 -> 0x3C02.
- Overflow and special values:
  - 0x7BFF+0x7BFF -> 0x7C00.
  - 0x7C00+0xFC00 -> 0x7E00.
  - 0x7C01+0x3C00 -> 0x7E00.
  - 0xFC00+0x3C00 -> 0xFC00.
- Subnormals and zeros:
  - 0x0001+0x0001 -> 0x0002.
  - 0x03FF+0x0001 -> 0x0400.
  - 0x8000+0x8000 -> 0x8000.
  - With FP_ADD_FTZ_EN, 0x0001+0x0001 -> 0x0000.
- Pipeline and reset:
  - Back-to-back stream of 1000 random pairs, one per cycle, matches a reference model at 2-cycle offset.
  - Assert rst_n mid-stream -> result 0 immediately, with no stale outputs after release.
